kb_keymap: RTL and testbench



---
 rtl/kb_pkg.sv | 21 ++
 rtl/kb_repeat_timer.sv | 30 +++
 rtl/kb_keymap.sv | 134 +++++++++++++
 tb/tb_kb_keymap.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 keymap decoder and its integration.
package kb_pkg;

  localparam logic [7:0] KB_BREAK = 8'hF0;
  localparam logic [7:0] KB_EXT   = 8'hE0;

  // Width of every cycle counter in the keymap; any int-sized delay fits.
  localparam int KB_CNT_W = 32;

  localparam int                        KB_DEFAULT_KEYS  = 6;
  localparam logic [KB_DEFAULT_KEYS*8-1:0] KB_DEFAULT_TABLE =
    {8'h29, 8'h2D, 8'h1B, 8'h1D, 8'h23, 8'h1C};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kb_state_e;

endpackage

// File: rtl/kb_repeat_timer.sv
// Loadable down-counter; expire pulses on the cycle the count reaches 1.
module kb_repeat_timer
  import kb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [KB_CNT_W-1:0] load_value,
  input  logic                cancel,
  output logic                expire
);

  logic [KB_CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (cancel) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == KB_CNT_W'(1));

endmodule

// File: rtl/kb_keymap.sv
// PS/2 scan-code decoder: prefix FSM, parallel key match array and optional
// auto-repeat, producing held levels and one-cycle press pulses per key.
module kb_keymap
  import kb_pkg::*;
#(
  parameter int                      NUM_KEYS       = 6,
  parameter logic [NUM_KEYS*8-1:0]   CODE_TABLE     = KB_DEFAULT_TABLE,
  parameter logic [NUM_KEYS-1:0]     EXT_MASK       = '0,
  parameter int unsigned             PREFIX_TIMEOUT = 2_000_000,
  parameter int unsigned             REPEAT_DELAY   = 0,
  parameter int unsigned             REPEAT_RATE    = 10_000_000,
  localparam int                     LK_W           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_done_tick,
  input  logic [7:0]          scan_code,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                any_held,
  output logic [LK_W-1:0]     last_key
);

  localparam bit REPEAT_ON = (REPEAT_DELAY != 0);

  // Asserts asynchronously, releases two clocks after reset goes high.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  kb_state_e           state, state_next;
  logic [KB_CNT_W-1:0] pfx_cnt;
  logic                is_prefix, data_tick, ext_cur, brk_cur, timeout;

  assign is_prefix = (scan_code == KB_BREAK) || (scan_code == KB_EXT);
  assign data_tick = scan_done_tick && !is_prefix;
  assign ext_cur   = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign brk_cur   = (state == ST_BRK) || (state == ST_EXT_BRK);
  assign timeout   = (state != ST_IDLE) && (pfx_cnt == KB_CNT_W'(PREFIX_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pfx_cnt <= '0;
    end else begin
      state <= state_next;
      if (scan_done_tick || state_next == ST_IDLE) pfx_cnt <= '0;
      else                                         pfx_cnt <= pfx_cnt + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (scan_done_tick) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == KB_BREAK)    state_next = ST_BRK;
          else if (scan_code == KB_EXT) state_next = ST_EXT;
        end
        ST_EXT: begin
          if (scan_code == KB_BREAK)   state_next = ST_EXT_BRK;
          else if (!is_prefix)         state_next = ST_IDLE;
        end
        default: begin
          if (!is_prefix) state_next = ST_IDLE;
        end
      endcase
    end else if (timeout) begin
      state_next = ST_IDLE;
    end
  end

  logic [NUM_KEYS-1:0] make_hit, brk_hit, new_press, held_next, rep_vec;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic hit;
    assign hit = data_tick && (scan_code == CODE_TABLE[i*8 +: 8]) && (ext_cur == EXT_MASK[i]);
    assign make_hit[i] = hit && !brk_cur;
    assign brk_hit[i]  = hit && brk_cur;
  end

  // A make on an already-held key is a keyboard typematic repeat and is dropped.
  assign new_press = make_hit & ~key_held;
  assign held_next = (key_held | make_hit) & ~brk_hit;

  logic [LK_W-1:0] last_key_next;

  always_comb begin
    last_key_next = last_key;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (new_press[i]) last_key_next = LK_W'(i);
    end
  end

  logic                rep_expire, rep_fire, rep_load, rep_cancel;
  logic [KB_CNT_W-1:0] rep_value;

  // A fresh make outranks a repeat expiry and restarts the initial delay.
  assign rep_fire   = REPEAT_ON && rep_expire && held_next[last_key] && !(|new_press);
  assign rep_load   = REPEAT_ON && ((|new_press) || rep_fire);
  assign rep_value  = (|new_press) ? KB_CNT_W'(REPEAT_DELAY) : KB_CNT_W'(REPEAT_RATE);
  assign rep_cancel = key_held[last_key] && brk_hit[last_key];
  assign rep_vec    = rep_fire ? (NUM_KEYS'(1) << last_key) : '0;

  kb_repeat_timer u_repeat (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (rep_load),
    .load_value (rep_value),
    .cancel     (rep_cancel),
    .expire     (rep_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_held  <= '0;
      key_press <= '0;
      last_key  <= '0;
    end else begin
      key_held  <= held_next;
      key_press <= new_press | rep_vec;
      last_key  <= last_key_next;
    end
  end

  assign any_held = |key_held;

endmodule

// File: tb/tb_kb_keymap.sv
// Directed bench for kb_keymap: three instances cover default decode with a
// short prefix timeout, extended-key masking, and auto-repeat timing.
module tb_kb_keymap;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] code = 8'h00;
  logic       tick_a = 1'b0, tick_b = 1'b0, tick_c = 1'b0;

  logic [5:0] held_a, press_a, held_b, press_b, held_c, press_c;
  logic       any_a, any_b, any_c;
  logic [2:0] last_a, last_b, last_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kb_keymap #(.PREFIX_TIMEOUT(30)) u_a (
    .clk(clk), .reset(reset), .scan_done_tick(tick_a), .scan_code(code),
    .key_held(held_a), .key_press(press_a), .any_held(any_a), .last_key(last_a)
  );

  kb_keymap #(.EXT_MASK(6'b000001)) u_b (
    .clk(clk), .reset(reset), .scan_done_tick(tick_b), .scan_code(code),
    .key_held(held_b), .key_press(press_b), .any_held(any_b), .last_key(last_b)
  );

  kb_keymap #(.REPEAT_DELAY(100), .REPEAT_RATE(20)) u_c (
    .clk(clk), .reset(reset), .scan_done_tick(tick_c), .scan_code(code),
    .key_held(held_c), .key_press(press_c), .any_held(any_c), .last_key(last_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tick lands on the posedge between two negedges; returns in the following cycle.
  task automatic send(input int which, input logic [7:0] b);
    @(negedge clk);
    code = b;
    case (which)
      0:       tick_a = 1'b1;
      1:       tick_b = 1'b1;
      default: tick_c = 1'b1;
    endcase
    @(negedge clk);
    tick_a = 1'b0;
    tick_b = 1'b0;
    tick_c = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(4);
    check("rst_held_a", held_a, 0);
    check("rst_press_a", press_a, 0);
    check("rst_any_a", any_a, 0);
    check("rst_last_a", last_a, 0);
    check("rst_held_b", held_b, 0);
    check("rst_held_c", held_c, 0);
    reset = 1'b1;
    idle(4);

    // Basic make / break on defaults
    send(0, 8'h1C);
    check("make_held", held_a, 6'b000001);
    check("make_press", press_a, 6'b000001);
    check("make_last", last_a, 0);
    check("make_any", any_a, 1);
    idle(1);
    check("press_one_cycle", press_a, 0);
    send(0, 8'hF0);
    send(0, 8'h1C);
    check("break_held", held_a, 0);
    check("break_press", press_a, 0);
    check("break_any", any_a, 0);

    // Typematic repeats from the keyboard
    send(0, 8'h1C);
    check("typ_first_press", press_a, 6'b000001);
    for (int i = 0; i < 4; i++) begin
      send(0, 8'h1C);
      check("typ_repeat_press", press_a, 0);
    end
    check("typ_held", held_a, 6'b000001);
    send(0, 8'hF0);
    send(0, 8'h1C);
    check("typ_release", held_a, 0);

    // Prefix timeout: F0 abandoned, so 23 is a make
    send(0, 8'hF0);
    idle(31);
    send(0, 8'h23);
    check("to_make_held", held_a, 6'b000010);
    check("to_make_press", press_a, 6'b000010);
    check("to_make_last", last_a, 1);

    // Just inside the timeout the F0 still applies
    send(0, 8'hF0);
    idle(27);
    send(0, 8'h23);
    check("to_inside_break", held_a, 0);

    // Unmatched code and non-extended key under E0
    send(0, 8'h55);
    check("unmatched_held", held_a, 0);
    check("unmatched_press", press_a, 0);
    send(0, 8'hE0);
    send(0, 8'h1C);
    check("ext_nomatch_a", held_a, 0);

    send(0, 8'h1C);
    send(0, 8'h1D);
    check("two_held", held_a, 6'b000101);
    check("two_last", last_a, 2);
    check("two_press", press_a, 6'b000100);

    // Extended-key mask on key 0
    send(1, 8'h1C);
    check("extm_plain_held", held_b, 0);
    check("extm_plain_press", press_b, 0);
    send(1, 8'hE0);
    send(1, 8'h1C);
    check("extm_make_held", held_b, 6'b000001);
    check("extm_make_press", press_b, 6'b000001);
    send(1, 8'h23);
    check("extm_other_key", held_b, 6'b000011);
    send(1, 8'hE0);
    send(1, 8'hF0);
    send(1, 8'h1C);
    check("extm_break", held_b, 6'b000010);
    send(1, 8'hE0);
    send(1, 8'hE0);
    send(1, 8'h1C);
    check("extm_double_e0", held_b, 6'b000011);
    check("extm_double_e0_press", press_b, 6'b000001);

    // Auto-repeat timing relative to tick cycle N
    send(2, 8'h1D);
    check("rep_press_n1", press_c, 6'b000100);
    check("rep_held", held_c, 6'b000100);
    check("rep_last", last_c, 2);
    idle(99);
    check("rep_n100_quiet", press_c, 0);
    idle(1);
    check("rep_n101", press_c, 6'b000100);
    idle(1);
    check("rep_n102_quiet", press_c, 0);
    idle(19);
    check("rep_n121", press_c, 6'b000100);
    idle(20);
    check("rep_n141", press_c, 6'b000100);
    idle(8);
    send(2, 8'h1B);
    check("retarget_press", press_c, 6'b001000);
    check("retarget_held", held_c, 6'b001100);
    check("retarget_last", last_c, 3);
    idle(10);
    check("old_target_stopped", press_c, 0);
    idle(89);
    check("retarget_n250_quiet", press_c, 0);
    idle(1);
    check("retarget_n251", press_c, 6'b001000);
    send(2, 8'hF0);
    send(2, 8'h1B);
    check("rep_release", held_c, 6'b000100);

    // Asynchronous reset in the middle of an E0 sequence
    send(0, 8'hE0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_held", held_a, 0);
    check("async_press", press_a, 0);
    check("async_any", any_a, 0);
    check("async_last", last_a, 0);
    check("async_held_c", held_c, 0);
    idle(2);
    reset = 1'b1;
    idle(4);
    send(0, 8'h1C);
    check("post_rst_press", press_a, 6'b000001);
    check("post_rst_held", held_a, 6'b000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
